crc_check_gen: RTL

//  Parametrised CRC-32 (IEEE 802.3) frame checker for the XGMII receive path.

---
 rtl/crc_check_gen.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/crc_check_gen.sv
// CRC-32 (IEEE 802.3) receive frame checker: beats pass through with 2-cycle latency, flags land on the Eof beat.
// Optional build macro STRIP_FCS_EN removes the 4 FCS bytes from the output stream.
module crc_check_gen #(
    parameter int          DATA_W   = 64,
    parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE  = 32'hC704DD7B,
    parameter int          MIN_LEN  = 64,
    localparam int         BYTES    = DATA_W / 8,
    localparam int         MOD_W    = $clog2(BYTES)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InDv,
    input  logic [DATA_W-1:0] InD,
    input  logic              InSof,
    input  logic              InEof,
    input  logic [MOD_W-1:0]  InMod,
    input  logic              InErr,
    input  logic              CntClr,
    output logic              OutDv,
    output logic [DATA_W-1:0] OutD,
    output logic              OutSof,
    output logic              OutEof,
    output logic [MOD_W-1:0]  OutMod,
    output logic [2:0]        OutErr,
    output logic [31:0]       FrmCnt,
    output logic [31:0]       CrcErrCnt
);
    localparam logic [31:0]  POLY       = 32'h04C11DB7;
    localparam logic [MOD_W:0] FULL_LANES = (MOD_W+1)'(BYTES);

    // Lane 0 sits in the top byte; each byte is shifted in LSB first.
    function automatic logic [31:0] crc_fold(input logic [31:0] crc_in,
                                             input logic [DATA_W-1:0] data,
                                             input logic [MOD_W:0] lanes);
        logic [31:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 0; i < BYTES; i++) begin
            if (i < int'(lanes)) begin
                for (int b = 0; b < 8; b++) begin
                    fb = c[31] ^ data[DATA_W - 8 - 8*i + b];
                    c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
                end
            end
        end
        return c;
    endfunction

    logic [31:0]      crc_reg, crc_base, crc_now;
    logic [15:0]      byte_cnt_reg, cnt_base, cnt_now;
    logic [16:0]      cnt_sum;
    logic             phy_reg, phy_now, in_frame_reg;
    logic             active, frame_end, runt_now;
    logic [MOD_W:0]   lanes_now;
    logic [2:0]       err_now;
    logic             drop_now;
    logic [MOD_W-1:0] mod_now;

    always_comb begin
        lanes_now = (InEof && InMod != '0) ? {1'b0, InMod} : FULL_LANES;
        active    = InDv && (InSof || in_frame_reg);
        frame_end = active && InEof;
        crc_base  = InSof ? CRC_INIT : crc_reg;
        crc_now   = crc_fold(crc_base, InD, lanes_now);
        cnt_base  = InSof ? 16'd0 : byte_cnt_reg;
        cnt_sum   = {1'b0, cnt_base} + 17'(lanes_now);
        cnt_now   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        phy_now   = InErr || (!InSof && phy_reg);
        runt_now  = cnt_now < 16'(MIN_LEN);
        err_now   = frame_end ? {phy_now, runt_now, crc_now != RESIDUE} : 3'b000;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            crc_reg      <= CRC_INIT;
            byte_cnt_reg <= '0;
            phy_reg      <= 1'b0;
            in_frame_reg <= 1'b0;
        end else if (active) begin
            crc_reg      <= crc_now;
            byte_cnt_reg <= cnt_now;
            phy_reg      <= phy_now;
            in_frame_reg <= !InEof;
        end
    end

`ifdef STRIP_FCS_EN
    logic             s1_open_reg;
    logic [MOD_W-1:0] promo_mod;

    // An Eof beat holding only FCS bytes is dropped; the beat ahead of it closes the frame.
    // The promotion relies on that beat still sitting in stage 1 (no gap before a short Eof beat).
    always_comb begin
        drop_now  = frame_end && !InSof && (lanes_now <= (MOD_W+1)'(4));
        promo_mod = MOD_W'(BYTES - 4 + int'(lanes_now));
        if (frame_end && lanes_now <= (MOD_W+1)'(4))
            mod_now = '0;
        else if (frame_end)
            mod_now = MOD_W'(int'(lanes_now) - 4);
        else
            mod_now = InMod;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            s1_open_reg <= 1'b0;
        else
            s1_open_reg <= active && !InEof;
    end
`else
    assign drop_now = 1'b0;
    assign mod_now  = InMod;
`endif

    logic              s1_dv_reg, s1_sof_reg, s1_eof_reg, s1_end_reg, out_end_reg;
    logic [DATA_W-1:0] s1_d_reg;
    logic [MOD_W-1:0]  s1_mod_reg;
    logic [2:0]        s1_err_reg;
    logic              keep;

    assign keep = InDv && !drop_now;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_dv_reg  <= 1'b0;
            s1_d_reg   <= '0;
            s1_sof_reg <= 1'b0;
            s1_eof_reg <= 1'b0;
            s1_mod_reg <= '0;
            s1_err_reg <= 3'b000;
            s1_end_reg <= 1'b0;
        end else begin
            s1_dv_reg  <= keep;
            s1_d_reg   <= keep ? InD : '0;
            s1_sof_reg <= keep && InSof;
            s1_eof_reg <= keep && InEof;
            s1_mod_reg <= keep ? mod_now : '0;
            s1_err_reg <= drop_now ? 3'b000 : err_now;
            s1_end_reg <= frame_end && !drop_now;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            OutDv       <= 1'b0;
            OutD        <= '0;
            OutSof      <= 1'b0;
            OutEof      <= 1'b0;
            OutMod      <= '0;
            OutErr      <= 3'b000;
            out_end_reg <= 1'b0;
        end else begin
            OutDv       <= s1_dv_reg;
            OutD        <= s1_d_reg;
            OutSof      <= s1_sof_reg;
            OutEof      <= s1_eof_reg;
            OutMod      <= s1_mod_reg;
            OutErr      <= s1_err_reg;
            out_end_reg <= s1_end_reg;
`ifdef STRIP_FCS_EN
            if (s1_open_reg && drop_now) begin
                OutEof      <= 1'b1;
                OutMod      <= promo_mod;
                OutErr      <= err_now;
                out_end_reg <= 1'b1;
            end
`endif
        end
    end

    logic [31:0] frm_cnt_reg, crc_err_cnt_reg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frm_cnt_reg     <= '0;
            crc_err_cnt_reg <= '0;
        end else if (CntClr) begin
            frm_cnt_reg     <= '0;
            crc_err_cnt_reg <= '0;
        end else if (out_end_reg) begin
            if (frm_cnt_reg != 32'hFFFFFFFF)
                frm_cnt_reg <= frm_cnt_reg + 32'd1;
            if (OutErr[0] && crc_err_cnt_reg != 32'hFFFFFFFF)
                crc_err_cnt_reg <= crc_err_cnt_reg + 32'd1;
        end
    end

    assign FrmCnt    = frm_cnt_reg;
    assign CrcErrCnt = crc_err_cnt_reg;

endmodule
